// File: rtl/mem_io_pkg.sv
// ---------------------------------------------------------------------------
// mem_io_pkg
// Shared constants for the MEM stage memory-mapped I/O region.
// The I/O region is selected by address bit IO_SEL_BIT. Inside it, the
// register is chosen by the low address byte. Bits [1:0] are ignored because
// every access is a full word.
// ---------------------------------------------------------------------------
package mem_io_pkg;

    localparam int IO_SEL_BIT = 7;

    localparam logic [7:0] ADDR_OUT0 = 8'h80;
    localparam logic [7:0] ADDR_OUT1 = 8'h84;
    localparam logic [7:0] ADDR_OUT2 = 8'h88;
    localparam logic [7:0] ADDR_IN0  = 8'hC0;
    localparam logic [7:0] ADDR_IN1  = 8'hC4;
    localparam logic [7:0] ADDR_CNT  = 8'hC8;

    // Decoded I/O target. Every unmapped address collapses to IO_NONE.
    typedef enum logic [2:0] {
        IO_NONE = 3'd0,
        IO_OUT0 = 3'd1,
        IO_OUT1 = 3'd2,
        IO_OUT2 = 3'd3,
        IO_IN0  = 3'd4,
        IO_IN1  = 3'd5,
        IO_CNT  = 3'd6
    } ioTarget_t;

    // Word-aligned decode of the low address byte. The caller qualifies the
    // result with the region-select bit.
    function automatic ioTarget_t decodeIo(input logic [7:0] addr);
        logic [7:0] wordAddr;
        wordAddr = {addr[7:2], 2'b00};
        case (wordAddr)
            ADDR_OUT0: decodeIo = IO_OUT0;
            ADDR_OUT1: decodeIo = IO_OUT1;
            ADDR_OUT2: decodeIo = IO_OUT2;
            ADDR_IN0:  decodeIo = IO_IN0;
            ADDR_IN1:  decodeIo = IO_IN1;
            ADDR_CNT:  decodeIo = IO_CNT;
            default:   decodeIo = IO_NONE;
        endcase
    endfunction

endpackage

// File: rtl/io_input_sync.sv
// ---------------------------------------------------------------------------
// io_input_sync
// Two-flop synchronizer for a bus of asynchronous input bits. Each bit is
// synchronized independently. The bus is therefore not coherent while it is
// changing, which is acceptable for slowly changing switch inputs.
// Ports:
//   clock    - destination clock
//   resetn   - synchronous active-low reset; clears both stages
//   async_i  - asynchronous input bus
//   sync_o   - second-stage (synchronized) value
// ---------------------------------------------------------------------------
module io_input_sync #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    // First stage may go metastable. The second stage gives it a full cycle
    // to resolve before anything downstream looks at it.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= async_i;
            stage2_q <= stage1_q;
        end
    end

    assign sync_o = stage2_q;

endmodule

// File: rtl/mem_stage_io.sv
// ---------------------------------------------------------------------------
// mem_stage_io
// MEM stage of the five-stage pipeline. It holds a word-addressed data RAM
// and a small memory-mapped I/O block (three output registers, two
// synchronized input ports and a free-running cycle counter).
// Ports:
//   clock, resetn       - stage clock, synchronous active-low reset
//   malu                - byte address from EXE/MEM (bit 7 selects I/O)
//   mb                  - store data from EXE/MEM
//   mwmem               - store enable from EXE/MEM
//   in_port0, in_port1  - asynchronous external inputs
//   mmo                 - combinational load data to MEM/WB
//   out_port0..2        - output port registers
// ---------------------------------------------------------------------------
module mem_stage_io
    import mem_io_pkg::*;
#(
    parameter int RAM_WORDS = 32
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic        mwmem,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    output logic [31:0] mmo,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic [31:0] out_port2
);

    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    logic [31:0] ram [RAM_WORDS];

    logic          ioSel;
    ioTarget_t     ioTarget;
    logic [AW-1:0] ramAddr;
    logic          ramWrite;
    logic          ioWrite;

    logic [31:0] outPort0_q, outPort0_d;
    logic [31:0] outPort1_q, outPort1_d;
    logic [31:0] outPort2_q, outPort2_d;
    logic [31:0] counter_q,  counter_d;

    logic [31:0] inSync0;
    logic [31:0] inSync1;

    // Address decode. The RAM index wraps modulo the RAM depth, so RAM words
    // alias through the whole RAM half of the low byte. High address bits
    // play no part in the decode.
    always_comb begin
        ioSel    = malu[IO_SEL_BIT];
        ioTarget = ioSel ? decodeIo(malu[7:0]) : IO_NONE;
        ramAddr  = AW'(malu[6:2]) & AW'(RAM_WORDS - 1);
        ramWrite = resetn && mwmem && !ioSel;
        ioWrite  = resetn && mwmem && ioSel;
    end

    io_input_sync #(.WIDTH(32)) uSync0 (
        .clock  (clock),
        .resetn (resetn),
        .async_i(in_port0),
        .sync_o (inSync0)
    );

    io_input_sync #(.WIDTH(32)) uSync1 (
        .clock  (clock),
        .resetn (resetn),
        .async_i(in_port1),
        .sync_o (inSync1)
    );

    // Data RAM: synchronous write, asynchronous read. It has no reset, so its
    // contents survive a mid-run reset. The write is gated by resetn so that
    // a store in a reset cycle is dropped.
    always_ff @(posedge clock) begin
        if (ramWrite) begin
            ram[ramAddr] <= mb;
        end
    end

    // Next state for the I/O registers. A store to the counter address takes
    // priority over the free-running increment.
    always_comb begin
        outPort0_d = outPort0_q;
        outPort1_d = outPort1_q;
        outPort2_d = outPort2_q;
        counter_d  = counter_q + 32'd1;
        if (ioWrite) begin
            case (ioTarget)
                IO_OUT0: outPort0_d = mb;
                IO_OUT1: outPort1_d = mb;
                IO_OUT2: outPort2_d = mb;
                IO_CNT:  counter_d  = mb;
                default: ;
            endcase
        end
    end

    // I/O state registers. Reset takes precedence over any store in the
    // same cycle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            outPort0_q <= '0;
            outPort1_q <= '0;
            outPort2_q <= '0;
            counter_q  <= '0;
        end else begin
            outPort0_q <= outPort0_d;
            outPort1_q <= outPort1_d;
            outPort2_q <= outPort2_d;
            counter_q  <= counter_d;
        end
    end

    // Load path: purely combinational from the address. Reads see the
    // pre-store value, which gives read-before-write in the store cycle.
    always_comb begin
        mmo = 32'h0;
        if (!ioSel) begin
            mmo = ram[ramAddr];
        end else begin
            case (ioTarget)
                IO_OUT0: mmo = outPort0_q;
                IO_OUT1: mmo = outPort1_q;
                IO_OUT2: mmo = outPort2_q;
                IO_IN0:  mmo = inSync0;
                IO_IN1:  mmo = inSync1;
                IO_CNT:  mmo = counter_q;
                default: mmo = 32'h0;
            endcase
        end
    end

    assign out_port0 = outPort0_q;
    assign out_port1 = outPort1_q;
    assign out_port2 = outPort2_q;

endmodule
